// File: rtl/clk_div_monitor_if.sv
// clk_div_monitor_if: divider-side inputs and status outputs of clk_div_monitor
// master: drives the divider observation and control inputs, reads status
// slave : the monitor itself
interface clk_div_monitor_if #(
    parameter int ERR_CNT_W = 8
);
    logic                 i_div_clk;
    logic [3:0]           i_div_ratio;
    logic                 i_clk_en;
    logic                 i_mon_en;
    logic                 i_err_clr;
    logic [4:0]           o_period;
    logic                 o_period_vld;
    logic                 o_lock;
    logic                 o_bypass;
    logic                 o_err;
    logic [ERR_CNT_W-1:0] o_err_cnt;
    modport master (
        output i_div_clk, i_div_ratio, i_clk_en, i_mon_en, i_err_clr,
        input  o_period, o_period_vld, o_lock, o_bypass, o_err, o_err_cnt
    );
    modport slave (
        input  i_div_clk, i_div_ratio, i_clk_en, i_mon_en, i_err_clr,
        output o_period, o_period_vld, o_lock, o_bypass, o_err, o_err_cnt
    );
endinterface

// File: rtl/clk_div_monitor.sv
// clk_div_monitor: checks period and duty of the integer divider output against the programmed ratio
// i_ref_clk    : reference clock shared with the divider
// i_rst_n      : asynchronous active-low reset
// mon.i_*      : divided clock, ratio, divider enable, monitor enable, error clear
// mon.o_*      : last period + strobe, lock, bypass, sticky error, saturating error count
module clk_div_monitor #(
    parameter int LOCK_CNT  = 4,
    parameter int ERR_CNT_W = 8
) (
    input logic               i_ref_clk,
    input logic               i_rst_n,
    clk_div_monitor_if.slave  mon
);
    typedef enum logic [1:0] {IDLE, ALIGN, MEASURE} state_t;
    localparam logic [3:0]           LOCK     = 4'(LOCK_CNT);
    localparam logic [ERR_CNT_W-1:0] ECNT_ONE = 1;
    state_t               state_q, state_d;
    logic                 d1_q, d2_q, en_q, bypass_q;
    logic                 lock_q, lock_d, err_q, err_d, vld_q, vld_d;
    logic [3:0]           ratio_q, good_q, good_d;
    logic [4:0]           cnt_q, cnt_d, hi_q, hi_d, period_q, period_d;
    logic [ERR_CNT_W-1:0] ecnt_q, ecnt_d;
    logic                 rise, bypass, cfg_chg, timeout, pass, err_ev;
    logic [4:0]           two_n, half_lo, half_hi;
    assign rise    = d1_q & ~d2_q;
    assign bypass  = ~mon.i_clk_en | (mon.i_div_ratio < 4'd2);
    assign cfg_chg = (mon.i_div_ratio != ratio_q) | (mon.i_clk_en != en_q);
    assign two_n   = {mon.i_div_ratio, 1'b0};
    assign half_lo = {2'b0, mon.i_div_ratio[3:1]};
    assign half_hi = half_lo + {4'b0, mon.i_div_ratio[0]};
    // odd ratios may split high/low either way round
    assign pass    = (cnt_q == {1'b0, mon.i_div_ratio}) & ((hi_q == half_lo) | (hi_q == half_hi));
    // cnt_q counts cycles since the last rise, so it doubles as the stuck-output watchdog
    assign timeout = ~rise & (cnt_q >= two_n);
    always_comb begin
        state_d  = state_q;
        cnt_d    = (cnt_q != 5'd31) ? cnt_q + 5'd1 : cnt_q;
        hi_d     = (d1_q && hi_q != 5'd31) ? hi_q + 5'd1 : hi_q;
        good_d   = good_q;
        lock_d   = lock_q;
        vld_d    = 1'b0;
        period_d = period_q;
        err_ev   = 1'b0;
        if (~mon.i_mon_en | bypass) begin
            state_d = IDLE;
            cnt_d   = '0;
            hi_d    = '0;
            good_d  = '0;
            lock_d  = 1'b0;
        end else if (state_q == IDLE) begin
            state_d = ALIGN;
            cnt_d   = '0;
            hi_d    = '0;
        end else if (cfg_chg) begin
            state_d = ALIGN;
            cnt_d   = '0;
            hi_d    = '0;
            good_d  = '0;
            lock_d  = 1'b0;
        end else if (timeout) begin
            err_ev  = 1'b1;
            state_d = ALIGN;
            cnt_d   = '0;
            hi_d    = '0;
            good_d  = '0;
            lock_d  = 1'b0;
        end else if (rise) begin
            state_d = MEASURE;
            cnt_d   = 5'd1;
            hi_d    = 5'd1;
            if (state_q == ALIGN) begin
                good_d = '0;
            end else begin
                vld_d    = 1'b1;
                period_d = cnt_q;
                if (pass) begin
                    good_d = (good_q == LOCK) ? good_q : good_q + 4'd1;
                    lock_d = lock_q | (good_d == LOCK);
                end else begin
                    err_ev = 1'b1;
                    good_d = '0;
                    lock_d = 1'b0;
                end
            end
        end
        err_d  = err_ev | (err_q & ~mon.i_err_clr);
        // an error in the clear cycle wins and restarts the count at one
        ecnt_d = err_ev ? (mon.i_err_clr ? ECNT_ONE : (&ecnt_q ? ecnt_q : ecnt_q + ECNT_ONE))
                        : (mon.i_err_clr ? '0 : ecnt_q);
    end
    always_ff @(posedge i_ref_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q  <= IDLE;
            d1_q     <= 1'b0;
            d2_q     <= 1'b0;
            en_q     <= 1'b0;
            ratio_q  <= '0;
            bypass_q <= 1'b0;
            cnt_q    <= '0;
            hi_q     <= '0;
            good_q   <= '0;
            lock_q   <= 1'b0;
            vld_q    <= 1'b0;
            period_q <= '0;
            err_q    <= 1'b0;
            ecnt_q   <= '0;
        end else begin
            state_q  <= state_d;
            d1_q     <= mon.i_div_clk;
            d2_q     <= d1_q;
            en_q     <= mon.i_clk_en;
            ratio_q  <= mon.i_div_ratio;
            bypass_q <= bypass;
            cnt_q    <= cnt_d;
            hi_q     <= hi_d;
            good_q   <= good_d;
            lock_q   <= lock_d;
            vld_q    <= vld_d;
            period_q <= period_d;
            err_q    <= err_d;
            ecnt_q   <= ecnt_d;
        end
    end
    assign mon.o_period     = period_q;
    assign mon.o_period_vld = vld_q;
    assign mon.o_lock       = lock_q;
    assign mon.o_bypass     = bypass_q;
    assign mon.o_err        = err_q;
    assign mon.o_err_cnt    = ecnt_q;
endmodule

// File: tb/tb_clk_div_monitor.sv
// tb_clk_div_monitor: scoreboard bench for clk_div_monitor
module tb_clk_div_monitor;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_tests = 0;
    int   n_fail = 0;
    int   pend = 0;
    int   exp_q[$];
    clk_div_monitor_if #(.ERR_CNT_W(8)) mon ();
    clk_div_monitor #(.LOCK_CNT(4), .ERR_CNT_W(8)) dut (
        .i_ref_clk (clk),
        .i_rst_n   (rst_n),
        .mon       (mon)
    );
    always #5 clk = ~clk;
    task automatic check(input string tag, input int got, input int exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask
    // one divider period; its rise completes the previous period, whose length is then expected
    task automatic gen(input int hi, input int lo);
        if (pend != 0) exp_q.push_back(pend);
        for (int i = 0; i < hi + lo; i++) begin
            mon.i_div_clk = (i < hi);
            tick(1);
        end
        pend = hi + lo;
    endtask
    task automatic burst(input int n, input int hi, input int lo);
        for (int i = 0; i < n; i++) gen(hi, lo);
    endtask
    task automatic toggle(input int n);
        for (int i = 0; i < n; i++) begin
            mon.i_div_clk = ~mon.i_div_clk;
            tick(1);
        end
        mon.i_div_clk = 1'b0;
    endtask
    always @(negedge clk) begin
        if (mon.o_period_vld) begin
            if (exp_q.size() == 0) check("unexpected_vld", int'(mon.o_period), 0);
            else check("period", int'(mon.o_period), exp_q.pop_front());
        end
    end
    task automatic check_zero(input string tag);
        check({tag, "_period"}, int'(mon.o_period), 0);
        check({tag, "_vld"}, int'(mon.o_period_vld), 0);
        check({tag, "_lock"}, int'(mon.o_lock), 0);
        check({tag, "_bypass"}, int'(mon.o_bypass), 0);
        check({tag, "_err"}, int'(mon.o_err), 0);
        check({tag, "_err_cnt"}, int'(mon.o_err_cnt), 0);
    endtask
    initial begin
        mon.i_div_clk = 1'b0;
        mon.i_div_ratio = 4'd4;
        mon.i_clk_en = 1'b1;
        mon.i_mon_en = 1'b1;
        mon.i_err_clr = 1'b0;
        #1;
        check_zero("reset");
        tick(3);
        rst_n = 1'b1;
        tick(2);
        // ratio 4: lock on the 4th good period
        burst(4, 2, 2);
        check("r4_lock_early", int'(mon.o_lock), 0);
        gen(2, 2);
        check("r4_lock", int'(mon.o_lock), 1);
        check("r4_err", int'(mon.o_err), 0);
        // ratio 5 with both high/low splits
        mon.i_div_ratio = 4'd5;
        pend = 0;
        tick(2);
        check("r5_realign_lock", int'(mon.o_lock), 0);
        for (int i = 0; i < 5; i++) gen((i % 2 == 0) ? 2 : 3, (i % 2 == 0) ? 3 : 2);
        check("r5_lock", int'(mon.o_lock), 1);
        check("r5_err_cnt", int'(mon.o_err_cnt), 0);
        // bypass cases: ratio 1, ratio 0, clk_en low
        mon.i_div_ratio = 4'd1;
        pend = 0;
        toggle(12);
        check("byp1", int'(mon.o_bypass), 1);
        check("byp1_lock", int'(mon.o_lock), 0);
        mon.i_div_ratio = 4'd0;
        toggle(12);
        check("byp0", int'(mon.o_bypass), 1);
        mon.i_div_ratio = 4'd4;
        mon.i_clk_en = 1'b0;
        toggle(12);
        check("byp_en", int'(mon.o_bypass), 1);
        check("byp_err", int'(mon.o_err), 0);
        mon.i_clk_en = 1'b1;
        tick(2);
        check("byp_exit", int'(mon.o_bypass), 0);
        // stuck output: timeout exactly 2N cycles after the last rise
        burst(5, 2, 2);
        check("pre_to_lock", int'(mon.o_lock), 1);
        pend = 0;
        tick(5);
        check("to_early", int'(mon.o_err), 0);
        tick(1);
        check("to_err", int'(mon.o_err), 1);
        check("to_err_cnt", int'(mon.o_err_cnt), 1);
        check("to_lock", int'(mon.o_lock), 0);
        burst(5, 2, 2);
        check("to_relock", int'(mon.o_lock), 1);
        check("to_sticky", int'(mon.o_err), 1);
        fork
            gen(2, 2);
            begin
                mon.i_err_clr = 1'b1;
                tick(1);
                mon.i_err_clr = 1'b0;
            end
        join
        check("clr_err", int'(mon.o_err), 0);
        check("clr_err_cnt", int'(mon.o_err_cnt), 0);
        // ratio 4 -> 8 in the middle of a period: realign, no error
        exp_q.push_back(pend);
        pend = 0;
        mon.i_div_clk = 1'b1;
        tick(2);
        mon.i_div_ratio = 4'd8;
        mon.i_div_clk = 1'b0;
        tick(2);
        check("r8_lock_drop", int'(mon.o_lock), 0);
        burst(4, 4, 4);
        check("r8_lock_early", int'(mon.o_lock), 0);
        gen(4, 4);
        check("r8_lock", int'(mon.o_lock), 1);
        check("r8_err_cnt", int'(mon.o_err_cnt), 0);
        // back to 4, then one short period
        mon.i_div_ratio = 4'd4;
        pend = 0;
        tick(2);
        burst(5, 2, 2);
        check("inj_pre_lock", int'(mon.o_lock), 1);
        gen(2, 1);
        gen(2, 2);
        check("inj_err", int'(mon.o_err), 1);
        check("inj_err_cnt", int'(mon.o_err_cnt), 1);
        check("inj_lock", int'(mon.o_lock), 0);
        burst(3, 2, 2);
        check("inj_lock_early", int'(mon.o_lock), 0);
        gen(2, 2);
        check("inj_relock", int'(mon.o_lock), 1);
        // asynchronous reset between clock edges
        rst_n = 1'b0;
        pend = 0;
        #1;
        check_zero("async_rst");
        tick(2);
        rst_n = 1'b1;
        tick(2);
        burst(3, 2, 2);
        pend = 0;
        tick(2);
        check("queue_empty", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/clk_div_monitor.md
Name: clk_div_monitor

Overview:
Downstream checker for the integer clock divider. It runs on the divider's reference clock and samples the divided clock output. It measures the period and the high/low phase lengths in reference cycles and compares them against the programmed ratio. It reports lock, a sticky error and a saturating error count to the control/status register block.

Parameters:
LOCK_CNT, 4, consecutive good periods required before o_lock asserts (1..15)
ERR_CNT_W, 8, width of saturating error counter

Ports:
i_ref_clk  in  1  reference clock, same clock as divider
i_rst_n  in  1  asynchronous active-low reset
i_div_clk  in  1  divided clock from divider output
i_div_ratio  in  4  ratio currently programmed into divider
i_clk_en  in  1  divider enable, same signal driving divider
i_mon_en  in  1  monitor enable
i_err_clr  in  1  synchronous clear of o_err and o_err_cnt (pulse)
o_period  out  5  last measured period, in reference cycles
o_period_vld  out  1  one-cycle strobe, o_period updated
o_lock  out  1  LOCK_CNT consecutive good periods seen since last realign
o_bypass  out  1  divider is in pass-through (ratio 0/1 or clk_en=0); not checked
o_err  out  1  sticky error flag
o_err_cnt  out  ERR_CNT_W  saturating count of error events

Behaviour:
- Clock and reset: single clock i_ref_clk. Reset is asynchronous, active-low on i_rst_n.
- Reset values:
  - o_period=0, o_period_vld=0, o_lock=0, o_err=0, o_err_cnt=0.
  - o_bypass=0.
  - FSM=IDLE; internal counters, sample flops and ratio/enable shadow regs=0.
- Sampling: d1 <= i_div_clk, d2 <= d1 each cycle.
  - rise = d1 & ~d2; fall = ~d1 & d2.
  - No extra synchronizer; i_div_clk is launched from i_ref_clk.
- Bypass: bypass = ~i_clk_en | (i_div_ratio < 2).
  - o_bypass is registered, 1-cycle latency.
  - In bypass, the divider output is the raw reference clock and is not sampleable; the FSM is held in IDLE.
- Ratio shadow: ratio_q/en_q are registered every cycle.
  - cfg_chg = (i_div_ratio != ratio_q) | (i_clk_en != en_q).
- FSM states: IDLE, ALIGN, MEASURE.
  - IDLE: entered from any state when ~i_mon_en | bypass. Moves to ALIGN when i_mon_en & ~bypass.
  - ALIGN: waits for first rise. On rise: cnt<=1, hi<=1, good<=0 -> MEASURE.
  - MEASURE: cnt increments each cycle (saturates at 31). hi counts cycles while d1=1. On rise, the period check runs:
    - period = cnt; pass iff period == N (N = i_div_ratio) and hi is floor(N/2) or ceil(N/2).
    - o_period<=period, o_period_vld=1 for one cycle.
    - Pass: good++ (sat at LOCK_CNT). o_lock<=1 when good reaches LOCK_CNT.
    - Fail: error event, good<=0, o_lock<=0.
    - In either case cnt<=1, hi<=1, stay in MEASURE.
  - Timeout: in ALIGN or MEASURE, if the cycles since the last rise reach 2*N with no rise, that is an error event; then o_lock<=0 and FSM -> ALIGN (stuck divider output).
- Realign: cfg_chg while in ALIGN or MEASURE -> ALIGN. o_lock<=0, good<=0, partial measurement discarded. This is NOT an error; no timeout counted in that cycle.
- Error event: o_err<=1 (sticky); o_err_cnt increments, saturating at all-ones.
- i_err_clr: clears o_err and o_err_cnt next cycle. If an error event occurs in the same cycle, the error wins: o_err=1, o_err_cnt=1.
- Latency: the reference edge on which d1 first samples i_div_clk=1 is T. rise is evaluated from T, and o_period/o_period_vld are valid in the cycle after T.
- Priority: reset > (~i_mon_en|bypass) > cfg_chg > timeout > rise check.
- Reset mid-operation: all outputs return to reset values immediately (asynchronous). After release: ALIGN is entered on the next cycle if enabled.

Test Plan:
- ratio=4, clk_en=1, mon_en=1: o_period_vld every 4 cycles with o_period=4; o_lock rises after the 4th good period; o_err=0.
- ratio=5: high phase 2 or 3, low 3 or 2 accepted; o_period=5; lock after 4 periods; o_err_cnt=0.
- ratio=1, then ratio=0, then clk_en=0 with ratio=4: o_bypass=1, no o_period_vld, o_lock=0, o_err=0.
- ratio=4 locked, force i_div_clk=0: after 8 cycles with no rise, o_err=1, o_err_cnt=1, o_lock=0. Release: relock after 4 periods; o_err stays 1 until an i_err_clr pulse clears it and o_err_cnt -> 0.
- ratio 4->8 mid-period while locked: o_lock drops, no error. Next periods report 8; relock; o_err_cnt unchanged.
- Inject one 3-cycle period at ratio=4: o_period=3, o_err=1, o_err_cnt +1, o_lock=0, relock after 4 good periods. Assert i_rst_n low mid-period: all outputs 0 asynchronously.
